// File: rtl/approx_mul_err_monitor.sv
// Error statistics monitor for 8x8 approximate multipliers; optional max-error tracking via APPROX_ERR_MAX_TRACK_EN.
// Latency: a sample accepted at edge T is in the sums after edge T+2.
// Backpressure: in_ready is high only while RUN; samples offered otherwise are dropped.
module approx_mul_err_monitor #(
  parameter int N_SAMPLES = 65536,
  parameter int ACC_W     = 52,
  parameter int CNT_W     = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       IN1,
  input  logic [7:0]       IN2,
  input  logic [15:0]      aOut,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sum_sq_err,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             sat
`ifdef APPROX_ERR_MAX_TRACK_EN
  ,
  output logic [15:0]      max_abs_err,
  output logic [7:0]       max_IN1,
  output logic [7:0]       max_IN2
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

  state_t           state;
  logic [CNT_W-1:0] smp_cnt;
  logic             xfer;
  logic             start_ok;

  logic [15:0]      exact_c;
  logic [16:0]      diff_c;
  logic [16:0]      neg_c;
  logic [15:0]      adiff_c;

  logic             s1_vld;
  logic [15:0]      s1_adiff;
  logic             s2_vld;
  logic [15:0]      s2_adiff;
  logic [31:0]      s2_sq;

  logic [ACC_W:0]   sq_sum_c;
  logic [ACC_W:0]   abs_sum_c;

  assign xfer     = in_valid && in_ready;
  assign start_ok = start && ((state == IDLE) || (state == DONE));

  assign exact_c = 16'(IN1) * 16'(IN2);
  assign diff_c  = {1'b0, aOut} - {1'b0, exact_c};
  assign neg_c   = -diff_c;
  assign adiff_c = diff_c[16] ? neg_c[15:0] : diff_c[15:0];

  // One extra bit on each sum exposes the carry used for saturation.
  assign sq_sum_c  = {1'b0, sum_sq_err} + (ACC_W+1)'(s2_sq);
  assign abs_sum_c = {1'b0, sum_abs_err} + (ACC_W+1)'(s2_adiff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      smp_cnt  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            smp_cnt  <= '0;
          end
        end
        RUN: begin
          if (xfer) begin
            smp_cnt <= smp_cnt + CNT_W'(1);
            if (smp_cnt == LAST_IDX) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // With S1 empty, the last S2 update lands on this same edge.
          if (!s1_vld) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef APPROX_ERR_MAX_TRACK_EN
  logic [7:0] s1_in1, s1_in2, s2_in1, s2_in2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_adiff <= '0;
      s2_vld   <= 1'b0;
      s2_adiff <= '0;
      s2_sq    <= '0;
`ifdef APPROX_ERR_MAX_TRACK_EN
      s1_in1   <= '0;
      s1_in2   <= '0;
      s2_in1   <= '0;
      s2_in2   <= '0;
`endif
    end else begin
      s1_vld   <= xfer;
      if (xfer) s1_adiff <= adiff_c;
      s2_vld   <= s1_vld;
      s2_adiff <= s1_adiff;
      s2_sq    <= 32'(s1_adiff) * 32'(s1_adiff);
`ifdef APPROX_ERR_MAX_TRACK_EN
      if (xfer) begin
        s1_in1 <= IN1;
        s1_in2 <= IN2;
      end
      s2_in1 <= s1_in1;
      s2_in2 <= s1_in2;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_sq_err  <= '0;
      sum_abs_err <= '0;
      err_cnt     <= '0;
      sat         <= 1'b0;
`ifdef APPROX_ERR_MAX_TRACK_EN
      max_abs_err <= '0;
      max_IN1     <= '0;
      max_IN2     <= '0;
`endif
    end else if (start_ok) begin
      sum_sq_err  <= '0;
      sum_abs_err <= '0;
      err_cnt     <= '0;
      sat         <= 1'b0;
`ifdef APPROX_ERR_MAX_TRACK_EN
      max_abs_err <= '0;
      max_IN1     <= '0;
      max_IN2     <= '0;
`endif
    end else if (s2_vld) begin
      if (sq_sum_c[ACC_W]) begin
        sum_sq_err <= '1;
        sat        <= 1'b1;
      end else begin
        sum_sq_err <= sq_sum_c[ACC_W-1:0];
      end
      if (abs_sum_c[ACC_W]) begin
        sum_abs_err <= '1;
        sat         <= 1'b1;
      end else begin
        sum_abs_err <= abs_sum_c[ACC_W-1:0];
      end
      err_cnt <= err_cnt + CNT_W'(s2_adiff != 16'd0);
`ifdef APPROX_ERR_MAX_TRACK_EN
      // Strict compare keeps the first sample that reached the maximum.
      if (s2_adiff > max_abs_err) begin
        max_abs_err <= s2_adiff;
        max_IN1     <= s2_in1;
        max_IN2     <= s2_in2;
      end
`endif
    end
  end

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Directed bench for approx_mul_err_monitor with N_SAMPLES=4 and a 33-bit accumulator.
module tb_approx_mul_err_monitor;
  localparam int ACC_W = 33;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       IN1 = '0;
  logic [7:0]       IN2 = '0;
  logic [15:0]      aOut = '0;
  logic             busy, done, sat;
  logic [ACC_W-1:0] sum_sq_err, sum_abs_err;
  logic [CNT_W-1:0] err_cnt;
`ifdef APPROX_ERR_MAX_TRACK_EN
  logic [15:0]      max_abs_err;
  logic [7:0]       max_IN1, max_IN2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  approx_mul_err_monitor #(.N_SAMPLES(4), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .IN1(IN1), .IN2(IN2), .aOut(aOut), .busy(busy), .done(done),
    .sum_sq_err(sum_sq_err), .sum_abs_err(sum_abs_err), .err_cnt(err_cnt), .sat(sat)
`ifdef APPROX_ERR_MAX_TRACK_EN
    , .max_abs_err(max_abs_err), .max_IN1(max_IN1), .max_IN2(max_IN2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic offer(input logic [7:0] a, input logic [7:0] b, input logic [15:0] o);
    in_valid = 1'b1; IN1 = a; IN2 = b; aOut = o;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b expected 0", sat); end
    checks++; if (sum_sq_err !== '0 || sum_abs_err !== '0 || err_cnt !== '0) begin
      errors++; $display("FAIL reset_sums: got sq=%0d abs=%0d cnt=%0d expected 0/0/0", sum_sq_err, sum_abs_err, err_cnt);
    end
  endtask

  task automatic test_exact_run();
    pulse_start();
    checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL exact_start: got busy=%b rdy=%b expected 1/1", busy, in_ready); end
    for (int i = 0; i < 4; i++) offer(8'd3, 8'd5, 16'd15);
    checks++; if (in_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL exact_last_xfer: got rdy=%b done=%b expected 0/0", in_ready, done); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL exact_drain: got done=%b busy=%b expected 0/1", done, busy); end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL exact_done: got done=%b busy=%b expected 1/0", done, busy); end
    checks++; if (sum_sq_err !== '0 || sum_abs_err !== '0 || err_cnt !== '0) begin
      errors++; $display("FAIL exact_sums: got sq=%0d abs=%0d cnt=%0d expected 0/0/0", sum_sq_err, sum_abs_err, err_cnt);
    end
  endtask

  task automatic test_error_mix();
    pulse_start();
    offer(8'd3, 8'd5, 16'd20);
    checks++; if (sum_abs_err !== 33'd0) begin errors++; $display("FAIL mix_lat1: got abs=%0d expected 0", sum_abs_err); end
    offer(8'd10, 8'd10, 16'd90);
    checks++; if (sum_abs_err !== 33'd0) begin errors++; $display("FAIL mix_lat2: got abs=%0d expected 0", sum_abs_err); end
    offer(8'd3, 8'd5, 16'd15);
    checks++; if (sum_abs_err !== 33'd5 || sum_sq_err !== 33'd25 || err_cnt !== 8'd1) begin
      errors++; $display("FAIL mix_partial1: got sq=%0d abs=%0d cnt=%0d expected 25/5/1", sum_sq_err, sum_abs_err, err_cnt);
    end
    offer(8'd3, 8'd5, 16'd15);
    checks++; if (sum_abs_err !== 33'd15) begin errors++; $display("FAIL mix_partial2: got abs=%0d expected 15", sum_abs_err); end
    tick(); tick();
    checks++; if (done !== 1'b1 || sum_sq_err !== 33'd125 || sum_abs_err !== 33'd15 || err_cnt !== 8'd2 || sat !== 1'b0) begin
      errors++; $display("FAIL mix_final: got done=%b sq=%0d abs=%0d cnt=%0d sat=%b expected 1/125/15/2/0", done, sum_sq_err, sum_abs_err, err_cnt, sat);
    end
  endtask

  task automatic test_extremes();
    pulse_start();
    offer(8'd255, 8'd255, 16'd0);
    for (int i = 0; i < 3; i++) offer(8'd0, 8'd0, 16'd0);
    tick(); tick();
    checks++; if (sum_sq_err !== 33'd4228250625 || sum_abs_err !== 33'd65025 || err_cnt !== 8'd1 || sat !== 1'b0) begin
      errors++; $display("FAIL extremes: got sq=%0d abs=%0d cnt=%0d sat=%b expected 4228250625/65025/1/0", sum_sq_err, sum_abs_err, err_cnt, sat);
    end
`ifdef APPROX_ERR_MAX_TRACK_EN
    checks++; if (max_abs_err !== 16'd65025 || max_IN1 !== 8'd255 || max_IN2 !== 8'd255) begin
      errors++; $display("FAIL extremes_max: got %0d/%0d/%0d expected 65025/255/255", max_abs_err, max_IN1, max_IN2);
    end
`endif
  endtask

  task automatic test_saturation();
    pulse_start();
    for (int i = 0; i < 4; i++) offer(8'd0, 8'd0, 16'd65535);
    checks++; if (sat !== 1'b0 || sum_sq_err !== 33'd8589672450) begin
      errors++; $display("FAIL sat_pre: got sat=%b sq=%0d expected 0/8589672450", sat, sum_sq_err);
    end
    tick(); tick();
    checks++; if (sat !== 1'b1 || sum_sq_err !== 33'h1_FFFF_FFFF) begin
      errors++; $display("FAIL sat_sq: got sat=%b sq=%0d expected 1/8589934591", sat, sum_sq_err);
    end
    checks++; if (sum_abs_err !== 33'd262140 || err_cnt !== 8'd4) begin
      errors++; $display("FAIL sat_abs: got abs=%0d cnt=%0d expected 262140/4", sum_abs_err, err_cnt);
    end
  endtask

  task automatic test_handshake();
    pulse_start();
    checks++; if (sat !== 1'b0 || sum_sq_err !== '0 || done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL hs_restart: got sat=%b sq=%0d done=%b busy=%b expected 0/0/0/1", sat, sum_sq_err, done, busy);
    end
    offer(8'd3, 8'd5, 16'd20);
    tick(); tick();
    pulse_start();
    checks++; if (busy !== 1'b1 || in_ready !== 1'b1 || sum_abs_err !== 33'd5) begin
      errors++; $display("FAIL hs_start_in_run: got busy=%b rdy=%b abs=%0d expected 1/1/5", busy, in_ready, sum_abs_err);
    end
    offer(8'd10, 8'd10, 16'd90);
    offer(8'd3, 8'd5, 16'd15);
    offer(8'd3, 8'd5, 16'd15);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hs_full: got rdy=%b expected 0", in_ready); end
    in_valid = 1'b1; IN1 = 8'd0; IN2 = 8'd0; aOut = 16'd65535;
    tick(); tick(); tick();
    in_valid = 1'b0;
    checks++; if (done !== 1'b1 || sum_sq_err !== 33'd125 || sum_abs_err !== 33'd15 || err_cnt !== 8'd2 || in_ready !== 1'b0) begin
      errors++; $display("FAIL hs_extra_dropped: got done=%b sq=%0d abs=%0d cnt=%0d rdy=%b expected 1/125/15/2/0", done, sum_sq_err, sum_abs_err, err_cnt, in_ready);
    end
  endtask

  task automatic test_reset_midrun();
    pulse_start();
    offer(8'd255, 8'd255, 16'd0);
    offer(8'd255, 8'd255, 16'd0);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || sum_abs_err !== '0) begin
      errors++; $display("FAIL rst_async: got busy=%b rdy=%b abs=%0d expected 0/0/0", busy, in_ready, sum_abs_err);
    end
    tick();
    rst = 1'b0;
    tick(); tick();
    checks++; if (sum_abs_err !== '0 || err_cnt !== '0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_flush: got abs=%0d cnt=%0d done=%b busy=%b expected 0/0/0/0", sum_abs_err, err_cnt, done, busy);
    end
    pulse_start();
    offer(8'd3, 8'd5, 16'd20);
    offer(8'd10, 8'd10, 16'd90);
    offer(8'd3, 8'd5, 16'd15);
    offer(8'd3, 8'd5, 16'd15);
    tick(); tick();
    checks++; if (done !== 1'b1 || sum_sq_err !== 33'd125 || sum_abs_err !== 33'd15 || err_cnt !== 8'd2) begin
      errors++; $display("FAIL rst_clean_run: got done=%b sq=%0d abs=%0d cnt=%0d expected 1/125/15/2", done, sum_sq_err, sum_abs_err, err_cnt);
    end
  endtask

  initial begin
    tick(); tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_exact_run();
    test_error_mix();
    test_extremes();
    test_saturation();
    test_handshake();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
